seven_segment_capture: RTL and testbench
========================================

Name: seven_segment_capture

Overview:
- Inverse of the hex-to-segment encoder: watches a multiplexed, active-low 4-digit seven-segment bus (seg + anode) and reconstructs the 4-bit value shown on each digit.
- Used as an on-chip display monitor and self-check.
- Sits beside the display scan driver and reports per-digit values, frame completion and protocol errors.

Parameters:
- STABLE_CYCLES, 4: consecutive unchanged cycles required before capture (minimum 1).
- NUM_DIGITS, 4: number of anodes/digits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- seg  input  7  segment bus, active-low; seg[0]=a … seg[6]=g.
- an  input  NUM_DIGITS  anode enables, active-low.
- digits  output  4*NUM_DIGITS  captured values; digit i occupies bits [4i+3:4i].
- digit_valid  output  NUM_DIGITS  bit i set once digit i has been captured since reset.
- frame_done  output  1  one-cycle pulse when every digit has been captured since the last pulse.
- err_pattern  output  1  one-cycle pulse when a settled pattern is not in the decode table.
- err_anode  output  1  one-cycle pulse on entry to a state with more than one anode low.

Behaviour:
- Reset: digits=0, digit_valid=0, frame_done=0, err_pattern=0, err_anode=0, seen mask=0, stab_cnt=0, state=IDLE.
- Input stage:
  - seg and an are registered once into seg_q/an_q.
  - The "changed" flag compares seg_q/an_q against their previous values.
- Decode table, seg[6:0] to value:
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3
  - 0011001→4, 0010010→5, 0000010→6, 1111000→7
  - 0000000→8, 0010000→9, 0001000→A, 0000011→b
  - 1000110→C, 0100001→d, 0000110→E, 0001110→F
  - Any other pattern is invalid.
- FSM states: IDLE, SETTLE, CAPTURE, HOLD.
  - IDLE: an_q all high or multiple low. Go to SETTLE when exactly one bit is low; clear stab_cnt.
  - SETTLE: stab_cnt increments each unchanged cycle.
    - On change: clear stab_cnt; stay in SETTLE if still one-hot-low, else go to IDLE.
    - When stab_cnt==STABLE_CYCLES-1 and unchanged: go to CAPTURE.
  - CAPTURE (1 cycle): for the active digit i:
    - Valid pattern: write the decoded value to digits[i], set digit_valid[i] and seen[i].
    - Invalid pattern: pulse err_pattern; digits[i] and seen unchanged.
    - Next state is HOLD.
  - HOLD: no further capture until seg_q or an_q changes. Then go to SETTLE (one-hot) or IDLE.
- err_anode: pulses in the first cycle an_q has ≥2 bits low after having ≤1 low. The state then goes to IDLE.
- Latency: a stable input change at edge k updates digits at edge k+STABLE_CYCLES+2 (k+6 at default).
- Re-capturing an already-seen digit overwrites its value; seen is unchanged.
- frame_done:
  - Pulses the cycle after seen becomes all ones.
  - seen clears in that same cycle.
  - A capture that lands in the clearing cycle is recorded in the new mask.
- Registered outputs only. Pulses never last more than 1 cycle.
- rst mid-SETTLE or mid-CAPTURE aborts without writing anything.
- Counter width is $clog2(STABLE_CYCLES+1). The counter saturates and never wraps.

Optional Feature:
- Macro SEVEN_SEGMENT_CAPTURE_BLANK_EN.
- When defined:
  - Pattern 1111111 is legal (blank digit).
  - A blank capture sets blank[i] on an extra NUM_DIGITS-wide output `blank`, sets seen[i] and digit_valid[i], and leaves digits[i] unchanged.
  - A valid hex capture clears blank[i].
- When undefined: 1111111 raises err_pattern, and the `blank` port does not exist.

Decomposition:
- Shared package seven_seg_pkg holds:
  - SEG_BLANK constant (7'b1111111).
  - The 16-entry segment constants SEG_0..SEG_F, also used by the encoder.
  - FSM state typedef cap_state_t.
- One sub-module, seg_pattern_decode (combinational): seg[6:0] → value[3:0] plus valid.
- Anode one-hot check and digit index encode live in the top level.

Test Plan:
- an=1110 and seg=0110000 held for 10 cycles → digits[3:0]=3 at edge 6 after the change; digit_valid=0001; exactly 1 CAPTURE.
- Scan digits 0–3 showing 1, A, d, 8, each held 8 cycles → digits=16'h8DA1, digit_valid=1111, frame_done pulses once, one cycle after the last capture.
- seg toggles every 3 cycles on an=1101 (STABLE_CYCLES=4) → no capture; digits unchanged; no error.
- an=1110 seg=1010101 held 8 cycles → err_pattern pulses once; digits[3:0] unchanged. Then an=1100 → err_anode pulses once; state IDLE.
- rst asserted at stab_cnt=2 during SETTLE for digit 2 → all outputs 0 next edge; no capture occurs afterwards until a fresh stable window.
- With BLANK_EN: an=0111 seg=1111111 held 8 cycles → blank=1000, digit_valid[3]=1, no err_pattern. Without BLANK_EN: same stimulus → err_pattern pulse.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: active-low segment patterns (seg[0]=a .. seg[6]=g)
// for hex digits 0..F plus blank, and the capture FSM state type.
package seven_seg_pkg;

   localparam int unsigned SEG_W = 7;
   localparam int unsigned VAL_W = 4;

   localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
   localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
   localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
   localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
   localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
   localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
   localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
   localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
   localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
   localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
   localparam logic [SEG_W-1:0] SEG_A     = 7'b0001000;
   localparam logic [SEG_W-1:0] SEG_B     = 7'b0000011;
   localparam logic [SEG_W-1:0] SEG_C     = 7'b1000110;
   localparam logic [SEG_W-1:0] SEG_D     = 7'b0100001;
   localparam logic [SEG_W-1:0] SEG_E     = 7'b0000110;
   localparam logic [SEG_W-1:0] SEG_F     = 7'b0001110;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      CAPTURE = 2'd2,
      HOLD    = 2'd3
   } cap_state_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational inverse of the hex-to-segment encoder; valid_c low for any
// pattern outside the 16-entry table.
module seg_pattern_decode
   import seven_seg_pkg::*;
(
   input  logic [SEG_W-1:0] seg,
   output logic [VAL_W-1:0] value_c,
   output logic             valid_c
);

   // Table lookup on the active-low segment pattern
   always_comb begin
      value_c = '0;
      valid_c = 1'b1;
      case (seg)
         SEG_0:   value_c = 4'h0;
         SEG_1:   value_c = 4'h1;
         SEG_2:   value_c = 4'h2;
         SEG_3:   value_c = 4'h3;
         SEG_4:   value_c = 4'h4;
         SEG_5:   value_c = 4'h5;
         SEG_6:   value_c = 4'h6;
         SEG_7:   value_c = 4'h7;
         SEG_8:   value_c = 4'h8;
         SEG_9:   value_c = 4'h9;
         SEG_A:   value_c = 4'hA;
         SEG_B:   value_c = 4'hB;
         SEG_C:   value_c = 4'hC;
         SEG_D:   value_c = 4'hD;
         SEG_E:   value_c = 4'hE;
         SEG_F:   value_c = 4'hF;
         default: valid_c = 1'b0;
      endcase
   end

endmodule

// File: rtl/seven_segment_capture.sv
// Monitors a multiplexed active-low seven-segment bus and reconstructs the value
// shown on each digit once the pattern has been stable for STABLE_CYCLES cycles.
// Optional blank-digit support: define SEVEN_SEGMENT_CAPTURE_BLANK_EN.
module seven_segment_capture
   import seven_seg_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned NUM_DIGITS    = 4
)
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [SEG_W-1:0]        seg,
   input  logic [NUM_DIGITS-1:0]   an,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic [NUM_DIGITS-1:0]   digit_valid,
   output logic                    frame_done,
   output logic                    err_pattern,
   output logic                    err_anode
`ifdef SEVEN_SEGMENT_CAPTURE_BLANK_EN
   ,
   output logic [NUM_DIGITS-1:0]   blank
`endif
);

   localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   logic [SEG_W-1:0]      seg_q, seg_p;
   logic [NUM_DIGITS-1:0] an_q, an_p;
   logic [NUM_DIGITS-1:0] low_q, low_p;
   logic                  changed, one_hot, multi_q, multi_p;
   logic [IDX_W-1:0]      idx;
   cap_state_t            state, state_d;
   logic [CNT_W-1:0]      stab_cnt, stab_cnt_d;
   logic                  capture;
   logic [VAL_W-1:0]      dec_value;
   logic                  dec_valid, pat_ok;
   logic [NUM_DIGITS-1:0] seen, seen_d;

   // Input register plus one-cycle history used for change detection
   always_ff @(posedge clk) begin
      if (rst) begin
         seg_q <= '1;
         seg_p <= '1;
         an_q  <= '1;
         an_p  <= '1;
      end else begin
         seg_q <= seg;
         seg_p <= seg_q;
         an_q  <= an;
         an_p  <= an_q;
      end
   end

   // Change flag and anode population checks (x & (x-1) nonzero => two or more low)
   always_comb begin
      low_q   = ~an_q;
      low_p   = ~an_p;
      changed = (seg_q != seg_p) || (an_q != an_p);
      multi_q = (low_q & (low_q - NUM_DIGITS'(1))) != '0;
      multi_p = (low_p & (low_p - NUM_DIGITS'(1))) != '0;
      one_hot = (low_q != '0) && !multi_q;
   end

   // Active digit index from the one-hot-low anode vector
   always_comb begin
      idx = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (low_q[i]) idx = IDX_W'(i);
      end
   end

   seg_pattern_decode u_decode (
      .seg     (seg_q),
      .value_c (dec_value),
      .valid_c (dec_valid)
   );

`ifdef SEVEN_SEGMENT_CAPTURE_BLANK_EN
   logic is_blank;
   assign is_blank = (seg_q == SEG_BLANK);
   assign pat_ok   = dec_valid || is_blank;
`else
   assign pat_ok   = dec_valid;
`endif

   // FSM state and stability counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         stab_cnt <= '0;
      end else begin
         state    <= state_d;
         stab_cnt <= stab_cnt_d;
      end
   end

   // Next-state logic; a change during CAPTURE abandons the capture and restarts settling
   always_comb begin
      state_d    = state;
      stab_cnt_d = stab_cnt;
      capture    = 1'b0;
      case (state)
         IDLE: begin
            if (one_hot) begin
               state_d    = SETTLE;
               stab_cnt_d = '0;
            end
         end
         SETTLE: begin
            if (changed) begin
               stab_cnt_d = '0;
               state_d    = one_hot ? SETTLE : IDLE;
            end else if (stab_cnt == CNT_W'(STABLE_CYCLES - 1)) begin
               state_d = CAPTURE;
            end else if (stab_cnt != CNT_W'(STABLE_CYCLES)) begin
               stab_cnt_d = stab_cnt + CNT_W'(1);
            end
         end
         CAPTURE: begin
            if (changed) begin
               stab_cnt_d = '0;
               state_d    = one_hot ? SETTLE : IDLE;
            end else begin
               capture = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (changed) begin
               stab_cnt_d = '0;
               state_d    = one_hot ? SETTLE : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Seen mask: cleared the cycle after it fills, keeping any capture landing that cycle
   always_comb begin
      seen_d = (&seen) ? '0 : seen;
      if (capture && pat_ok) seen_d = seen_d | (NUM_DIGITS'(1) << idx);
   end

   // Registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         digits      <= '0;
         digit_valid <= '0;
         seen        <= '0;
         frame_done  <= 1'b0;
         err_pattern <= 1'b0;
         err_anode   <= 1'b0;
`ifdef SEVEN_SEGMENT_CAPTURE_BLANK_EN
         blank       <= '0;
`endif
      end else begin
         seen        <= seen_d;
         frame_done  <= &seen;
         err_pattern <= capture && !pat_ok;
         err_anode   <= multi_q && !multi_p;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (capture && (IDX_W'(i) == idx)) begin
               if (dec_valid) begin
                  digits[4*i +: 4] <= dec_value;
                  digit_valid[i]   <= 1'b1;
`ifdef SEVEN_SEGMENT_CAPTURE_BLANK_EN
                  blank[i]         <= 1'b0;
`endif
               end
`ifdef SEVEN_SEGMENT_CAPTURE_BLANK_EN
               else if (is_blank) begin
                  blank[i]       <= 1'b1;
                  digit_valid[i] <= 1'b1;
               end
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_seven_segment_capture.sv
// Scoreboard bench for seven_segment_capture: stimulus pushes expected output events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_seven_segment_capture;
   import seven_seg_pkg::*;

   localparam int EV_CAP   = 0;
   localparam int EV_FRAME = 1;
   localparam int EV_PAT   = 2;
   localparam int EV_AN    = 3;

   typedef struct {
      int          kind;
      int          cyc;
      logic [15:0] digits;
      logic [3:0]  valid;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [6:0]  seg = 7'b1111111;
   logic [3:0]  an  = 4'b1111;
   logic [15:0] digits;
   logic [3:0]  digit_valid;
   logic        frame_done, err_pattern, err_anode;
`ifdef SEVEN_SEGMENT_CAPTURE_BLANK_EN
   logic [3:0]  blank;
`endif

   int   cyc = 0;
   logic rst_q = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   int   n_cap = 0;
   ev_t  q[$];
   logic [15:0] prev_digits = '0;
   logic [3:0]  prev_valid = '0;

   seven_segment_capture #(.STABLE_CYCLES(4), .NUM_DIGITS(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .seg         (seg),
      .an          (an),
      .digits      (digits),
      .digit_valid (digit_valid),
      .frame_done  (frame_done),
      .err_pattern (err_pattern),
      .err_anode   (err_anode)
`ifdef SEVEN_SEGMENT_CAPTURE_BLANK_EN
      ,
      .blank       (blank)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= rst;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int kind, input int c, input logic [15:0] d, input logic [3:0] v);
      ev_t e;
      e.kind = kind; e.cyc = c; e.digits = d; e.valid = v;
      q.push_back(e);
   endtask

   task automatic pop_check(input int kind);
      ev_t e;
      if (q.size() == 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", kind, cyc);
      end else begin
         e = q.pop_front();
         chk("event_kind", 32'(kind), 32'(e.kind));
         chk("event_cycle", 32'(cyc), 32'(e.cyc));
         chk("event_digits", 32'(digits), 32'(e.digits));
         chk("event_valid", 32'(digit_valid), 32'(e.valid));
      end
   endtask

   // Monitor: output events sampled on the falling edge
   always @(negedge clk) begin
      if (dut.state == CAPTURE) n_cap++;
      if (!rst_q) begin
         if ((digits !== prev_digits) || (digit_valid !== prev_valid)) pop_check(EV_CAP);
         if (frame_done === 1'b1)  pop_check(EV_FRAME);
         if (err_pattern === 1'b1) pop_check(EV_PAT);
         if (err_anode === 1'b1)   pop_check(EV_AN);
      end
      prev_digits = digits;
      prev_valid  = digit_valid;
   end

   task automatic drive(input logic [3:0] a, input logic [6:0] s, output int c);
      @(posedge clk);
      #2;
      an  = a;
      seg = s;
      c   = cyc;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_digits"}, 32'(digits), 32'h0);
      chk({tag, "_valid"}, 32'(digit_valid), 32'h0);
      chk({tag, "_frame"}, 32'(frame_done), 32'h0);
      chk({tag, "_err_pat"}, 32'(err_pattern), 32'h0);
      chk({tag, "_err_an"}, 32'(err_anode), 32'h0);
   endtask

   initial begin
      int c;
      // Reset
      idle_cycles(3);
      @(negedge clk);
      check_zero("reset");
      chk("reset_state", 32'(dut.state), 32'(IDLE));
      @(posedge clk);
      #2 rst = 1'b0;
      idle_cycles(3);

      // Single stable digit 0 showing 3
      drive(4'b1110, SEG_3, c);
      push(EV_CAP, c + 7, 16'h0003, 4'b0001);
      idle_cycles(10);
      chk("single_capture_count", 32'(n_cap), 32'd1);
      drive(4'b1111, SEG_BLANK, c);
      idle_cycles(3);

      // Scan 1, A, d, 8 across digits 0..3
      drive(4'b1110, SEG_1, c);
      push(EV_CAP, c + 7, 16'h0001, 4'b0001);
      idle_cycles(8);
      drive(4'b1101, SEG_A, c);
      push(EV_CAP, c + 7, 16'h00A1, 4'b0011);
      idle_cycles(8);
      drive(4'b1011, SEG_D, c);
      push(EV_CAP, c + 7, 16'h0DA1, 4'b0111);
      idle_cycles(8);
      drive(4'b0111, SEG_8, c);
      push(EV_CAP, c + 7, 16'h8DA1, 4'b1111);
      push(EV_FRAME, c + 8, 16'h8DA1, 4'b1111);
      idle_cycles(8);
      chk("scan_digits", 32'(digits), 32'h8DA1);
      chk("scan_valid", 32'(digit_valid), 32'hF);

      // Segment toggling every 3 cycles never settles
      drive(4'b1101, SEG_2, c);
      for (int i = 0; i < 6; i++) begin
         idle_cycles(2);
         drive(4'b1101, (i % 2 == 0) ? SEG_5 : SEG_2, c);
      end
      idle_cycles(2);
      drive(4'b1111, SEG_BLANK, c);
      idle_cycles(3);
      chk("toggle_no_capture", 32'(n_cap), 32'd5);
      chk("toggle_digits", 32'(digits), 32'h8DA1);

      // Invalid pattern, then two anodes low
      drive(4'b1110, 7'b1010101, c);
      push(EV_PAT, c + 7, 16'h8DA1, 4'b1111);
      idle_cycles(8);
      drive(4'b1100, 7'b1010101, c);
      push(EV_AN, c + 2, 16'h8DA1, 4'b1111);
      idle_cycles(3);
      @(negedge clk);
      chk("anode_err_state", 32'(dut.state), 32'(IDLE));

      // Reset during SETTLE of digit 2 at stab_cnt == 2
      drive(4'b1011, SEG_7, c);
      idle_cycles(4);
      #2 rst = 1'b1;
      @(posedge clk);
      #2 rst = 1'b0;
      c = cyc;
      push(EV_CAP, c + 7, 16'h0700, 4'b0100);
      @(negedge clk);
      check_zero("mid_settle_reset");
      idle_cycles(10);

      // Blank pattern on digit 3
      drive(4'b0111, SEG_BLANK, c);
`ifdef SEVEN_SEGMENT_CAPTURE_BLANK_EN
      push(EV_CAP, c + 7, 16'h0700, 4'b1100);
`else
      push(EV_PAT, c + 7, 16'h0700, 4'b0100);
`endif
      idle_cycles(8);
      @(negedge clk);
`ifdef SEVEN_SEGMENT_CAPTURE_BLANK_EN
      chk("blank_mask", 32'(blank), 32'b1000);
`endif
      chk("total_captures", 32'(n_cap), 32'd8);
      idle_cycles(4);
      chk("scoreboard_drained", 32'(q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
